dmem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the single-port data memory.

---
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Bounded bursts per owner; read data registered per port with a one-cycle valid pulse.

module dmem_rd_port #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_fire,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = rd_fire;
    rdata_d  = rd_fire ? mem_rdata : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
endmodule

module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int NUM_PORTS = 2;
  localparam int CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_PORTS-1:0]             req, we, gnt, rvalid;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata, rdata;
  logic                             own_vld, own, cont, sel;

  assign req   = {m1_req, m0_req};
  assign we    = {m1_we, m0_we};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};

  // Owner keeps the memory while requesting, unless its burst is spent and the other waits.
  always_comb begin
    gnt     = '0;
    cont    = 1'b0;
    own_vld = (state_q != IDLE);
    own     = (state_q == OWN1);
    if (rst_n) begin
      if (own_vld && req[own] && ((cnt_q < MAX_CNT) || !req[~own])) begin
        gnt[own] = 1'b1;
        cont     = 1'b1;
      end else if (&req) begin
        gnt[~last_q] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    last_d  = last_q;
    cnt_d   = '0;
    if (gnt[0])      state_d = OWN0;
    else if (gnt[1]) state_d = OWN1;
    if (|gnt) begin
      last_d = gnt[1];
      // A continuing owner that ran a full burst uncontested starts a fresh burst.
      if (cont) cnt_d = (cnt_q == MAX_CNT) ? ONE_CNT : cnt_q + ONE_CNT;
      else      cnt_d = ONE_CNT;
    end
  end

  always_comb begin
    sel       = gnt[1];
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rw    = 1'b0;
    if (|gnt) begin
      mem_addr  = addr[sel];
      mem_wdata = wdata[sel];
      mem_rw    = we[sel];
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    dmem_rd_port #(.DATA_W(DATA_W)) u_rd (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_fire   (gnt[p] & ~we[p]),
      .mem_rdata (mem_rdata),
      .rvalid    (rvalid[p]),
      .rdata     (rdata[p])
    );
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];
  assign m0_rdata  = rdata[0];
  assign m1_rdata  = rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter: a queue-based reference model
// predicts grants, memory drive and read returns; a monitor compares each cycle.

module tb_dmem_arbiter;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rw;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory, 16 words
  logic        preload;
  logic [31:0] tbmem [16];
  assign mem_rdata = tbmem[mem_addr[3:0]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) tbmem[i] <= 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    end else if (mem_rw) begin
      tbmem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model state
  typedef struct {
    logic        g0, g1, rw, rv0, rv1;
    logic [31:0] addr, wdata;
  } rec_t;

  rec_t        gq[$];
  logic [31:0] rq0[$], rq1[$];
  logic [31:0] refmem [16];
  int          m_own, m_run, m_last;
  bit          m_pend [2];
  bit          s_req [2], s_we [2], s_gp [2];
  logic [31:0] s_addr [2], s_wdata [2];

  task automatic model_reset();
    m_own = -1; m_run = 0; m_last = 1;
    m_pend[0] = 0; m_pend[1] = 0;
    s_gp[0] = 0; s_gp[1] = 0; s_req[0] = 0; s_req[1] = 0;
    gq.delete(); rq0.delete(); rq1.delete();
  endtask

  task automatic model_step();
    int   w;
    bit   cont;
    rec_t r;
    r.rv0 = m_pend[0];
    r.rv1 = m_pend[1];
    w = -1; cont = 0;
    if (m_own >= 0 && s_req[m_own] && (m_run < MAXB || !s_req[1 - m_own])) begin
      w = m_own; cont = 1;
    end else if (s_req[0] && s_req[1]) w = 1 - m_last;
    else if (s_req[0]) w = 0;
    else if (s_req[1]) w = 1;
    r.g0 = (w == 0);
    r.g1 = (w == 1);
    r.addr = 0; r.wdata = 0; r.rw = 0;
    if (w >= 0) begin
      r.addr = s_addr[w]; r.wdata = s_wdata[w]; r.rw = s_we[w];
    end
    gq.push_back(r);
    s_gp[0] = r.g0; s_gp[1] = r.g1;
    m_pend[0] = 0; m_pend[1] = 0;
    if (w >= 0) begin
      m_run  = cont ? ((m_run == MAXB) ? 1 : m_run + 1) : 1;
      m_own  = w;
      m_last = w;
      if (s_we[w]) refmem[s_addr[w][3:0]] = s_wdata[w];
      else begin
        m_pend[w] = 1;
        if (w == 0) rq0.push_back(refmem[s_addr[w][3:0]]);
        else        rq1.push_back(refmem[s_addr[w][3:0]]);
      end
    end else begin
      m_own = -1; m_run = 0;
    end
  endtask

  // One cycle of protocol-respecting random stimulus: a request is held until granted.
  task automatic step(input int p0, input int p1);
    int pct [2];
    pct[0] = p0; pct[1] = p1;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      if (!(s_req[p] && !s_gp[p])) begin
        s_req[p]   = int'($urandom_range(99, 0)) < pct[p];
        s_we[p]    = 1'($urandom_range(1, 0));
        s_addr[p]  = 32'($urandom_range(15, 0));
        s_wdata[p] = $urandom;
      end
    end
    m0_req = s_req[0]; m0_we = s_we[0]; m0_addr = s_addr[0]; m0_wdata = s_wdata[0];
    m1_req = s_req[1]; m1_we = s_we[1]; m1_addr = s_addr[1]; m1_wdata = s_wdata[1];
    #1 model_step();
  endtask

  // Monitor: pops one expected record per modelled cycle
  always @(negedge clk) begin
    rec_t r;
    #2;
    if (gq.size() > 0) begin
      r = gq.pop_front();
      chk("m0_gnt", 32'(m0_gnt), 32'(r.g0));
      chk("m1_gnt", 32'(m1_gnt), 32'(r.g1));
      chk("mem_addr", mem_addr, r.addr);
      chk("mem_wdata", mem_wdata, r.wdata);
      chk("mem_rw", 32'(mem_rw), 32'(r.rw));
      chk("m0_rvalid", 32'(m0_rvalid), 32'(r.rv0));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(r.rv1));
      if (r.rv0 && rq0.size() > 0) chk("m0_rdata", m0_rdata, rq0.pop_front());
      if (r.rv1 && rq1.size() > 0) chk("m1_rdata", m1_rdata, rq1.pop_front());
    end
  end

  // Phase table: cycles, m0 request %, m1 request %
  int ph_cyc [12] = '{2, 10, 2, 5, 8, 2, 24, 2, 3, 3, 300, 200};
  int ph_p0  [12] = '{0, 100, 0, 100, 100, 0, 100, 0, 100, 0, 60, 30};
  int ph_p1  [12] = '{0, 0, 0, 0, 100, 0, 100, 0, 100, 100, 60, 80};

  initial begin
    for (int i = 0; i < 16; i++) refmem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    model_reset();
    preload = 1'b1;
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd7; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd9; m1_wdata = 32'h0;

    // Reset holds everything quiet even with both ports requesting
    repeat (3) @(negedge clk);
    preload = 1'b0;
    #1;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_tie_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("first_tie_m1_gnt", 32'(m1_gnt), 32'd0);
    #1;
    rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0;

    // Single port write then read back
    @(negedge clk);
    rst_n = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd3; m0_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("wr_mem_rw", 32'(mem_rw), 32'd1);
    chk("wr_mem_addr", mem_addr, 32'd3);
    chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    m0_we = 1'b0;
    #1;
    chk("rd_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("rd_mem_rw", 32'(mem_rw), 32'd0);
    @(negedge clk);
    m0_req = 1'b0;
    #1;
    chk("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    refmem[3] = 32'hDEAD_BEEF;
    rst_n = 1'b0;

    // Scoreboarded phases: lone burst, late contender, contention, release, random
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int ph = 0; ph < 12; ph++)
      for (int c = 0; c < ph_cyc[ph]; c++) step(ph_p0[ph], ph_p1[ph]);

    // Reset in the cycle after an m1 read grant
    @(negedge clk);
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd5;
    #1;
    chk("mid_m1_gnt", 32'(m1_gnt), 32'd1);
    @(negedge clk);
    m1_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("mid_rst_m1_rdata", m1_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd2;
    #1;
    chk("post_rst_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("post_rst_m1_gnt", 32'(m1_gnt), 32'd0);
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
